li_imm_encoder: RTL and testbench

//  Encodes a 32-bit constant load ("li rt, value") into the shortest MIPS I-type sequence.
//  It is the inverse of the immediate extender: it chooses the imm16/EOp pair that the

---
 rtl/li_imm_encoder_if.sv | 21 ++
 rtl/li_imm_encoder.sv | 90 +++++++++
 tb/tb_li_imm_encoder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/li_imm_encoder_if.sv
// li_imm_encoder_if: request handshake and instruction-stream handshake bundle.
interface li_imm_encoder_if #(parameter int CNT_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_value;
    logic [4:0]       in_rt;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [1:0]       out_eop;
    logic             out_last;
    logic [CNT_W-1:0] out_count;
    modport master (
        output in_valid, in_value, in_rt, out_ready,
        input  in_ready, out_valid, out_instr, out_eop, out_last, out_count
    );
    modport slave (
        input  in_valid, in_value, in_rt, out_ready,
        output in_ready, out_valid, out_instr, out_eop, out_last, out_count
    );
endinterface

// File: rtl/li_imm_encoder.sv
// li_imm_encoder: turns "li rt, value" into the shortest addiu/ori/lui(+ori) sequence,
// one registered instruction per output handshake.
module li_imm_encoder #(
    parameter int CNT_W        = 16,
    parameter bit SKIP_ZERO_RT = 1'b1
) (
    input logic              clk,
    input logic              reset,
    li_imm_encoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B} state_t;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [1:0] EOP_SEXT = 2'b00;
    localparam logic [1:0] EOP_ZEXT = 2'b01;
    localparam logic [1:0] EOP_LUI  = 2'b10;
    state_t           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [1:0]       eop_q, eop_d;
    logic             last_q, last_d;
    logic [4:0]       rt_q, rt_d;
    logic [15:0]      lo_q, lo_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      hi, lo;
    logic             is_sext, is_zext, is_lui, accept, skip, fire;
    assign hi      = bus.in_value[31:16];
    assign lo      = bus.in_value[15:0];
    assign is_sext = hi == {16{lo[15]}};
    assign is_zext = hi == '0;
    assign is_lui  = lo == '0;
    assign accept  = state_q == IDLE && bus.in_valid;
    assign skip    = SKIP_ZERO_RT && bus.in_rt == '0;
    assign fire    = state_q != IDLE && bus.out_ready;
    // last_q doubles as the class tag: only the lui+ori split leaves EMIT_A with last_q==0
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        eop_d   = eop_q;
        last_d  = last_q;
        rt_d    = rt_q;
        lo_d    = lo_q;
        count_d = count_q + CNT_W'(fire);
        case (state_q)
            IDLE: if (accept && !skip) begin
                state_d = EMIT_A;
                rt_d    = bus.in_rt;
                lo_d    = lo;
                instr_d = is_sext ? {OP_ADDIU, 5'd0, bus.in_rt, lo} :
                          is_zext ? {OP_ORI, 5'd0, bus.in_rt, lo} :
                                    {OP_LUI, 5'd0, bus.in_rt, hi};
                eop_d   = is_sext ? EOP_SEXT : is_zext ? EOP_ZEXT : EOP_LUI;
                last_d  = is_sext || is_zext || is_lui;
            end
            EMIT_A: if (fire) begin
                state_d = last_q ? IDLE : EMIT_B;
                instr_d = last_q ? instr_q : {OP_ORI, rt_q, rt_q, lo_q};
                eop_d   = last_q ? eop_q : EOP_ZEXT;
                last_d  = 1'b1;
            end
            EMIT_B: if (fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            instr_q <= '0;
            eop_q   <= '0;
            last_q  <= 1'b0;
            rt_q    <= '0;
            lo_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            eop_q   <= eop_d;
            last_q  <= last_d;
            rt_q    <= rt_d;
            lo_q    <= lo_d;
            count_q <= count_d;
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q != IDLE;
    assign bus.out_instr = instr_q;
    assign bus.out_eop   = eop_q;
    assign bus.out_last  = last_q;
    assign bus.out_count = count_q;
endmodule

// File: tb/tb_li_imm_encoder.sv
// tb_li_imm_encoder: vector table, directed corner sequences and a randomized run
// against an arithmetic reference model of the li encoding rules.
module tb_li_imm_encoder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    li_imm_encoder_if #(.CNT_W(2)) bus ();
    li_imm_encoder #(.CNT_W(2), .SKIP_ZERO_RT(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct packed {logic [31:0] instr; logic [1:0] eop; logic last;} out_t;
    typedef struct {logic [31:0] v; logic [4:0] rt; int n; logic [31:0] i0; logic [1:0] e0; logic [31:0] i1;} vec_t;
    out_t exp_q[$];
    int total = 0;
    int bad = 0;
    int model_cnt = 0;
    logic rand_mode = 1'b0;
    logic rdy_ctl = 1'b1;
    logic prev_stall = 1'b0;
    logic [31:0] prev_instr = '0;
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction
    function automatic void model_push(logic [31:0] v, logic [4:0] rt);
        int signed s = $signed(v);
        int unsigned u = v;
        int unsigned r = {27'd0, rt};
        if (rt == 5'd0) return;
        if (s >= -32768 && s <= 32767)
            exp_q.push_back(out_t'{32'h24000000 + (r << 16) + (u % 65536), 2'd0, 1'b1});
        else if (u < 65536)
            exp_q.push_back(out_t'{32'h34000000 + (r << 16) + u, 2'd1, 1'b1});
        else if (u % 65536 == 0)
            exp_q.push_back(out_t'{32'h3C000000 + (r << 16) + u / 65536, 2'd2, 1'b1});
        else begin
            exp_q.push_back(out_t'{32'h3C000000 + (r << 16) + u / 65536, 2'd2, 1'b0});
            exp_q.push_back(out_t'{32'h34000000 + (r << 21) + (r << 16) + (u % 65536), 2'd1, 1'b1});
        end
    endfunction
    always begin
        @(negedge clk);
        #2;
        bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_ctl;
    end
    // scoreboard: runs after all drivers so out_ready is the value used at the next edge
    always begin
        @(negedge clk);
        #3;
        if (!reset) begin
            exp_q.delete();
            model_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            chk("mon_count", 32'(bus.out_count), 32'(model_cnt % 4));
            chk("mon_in_ready", 32'(bus.in_ready), 32'(exp_q.size() == 0));
            chk("mon_out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            if (prev_stall) chk("mon_hold_instr", bus.out_instr, prev_instr);
            if (bus.out_valid && exp_q.size() != 0) begin
                chk("mon_instr", bus.out_instr, exp_q[0].instr);
                chk("mon_eop", 32'(bus.out_eop), 32'(exp_q[0].eop));
                chk("mon_last", 32'(bus.out_last), 32'(exp_q[0].last));
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    model_cnt++;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_instr = bus.out_instr;
        end
    end
    task automatic tick();
        @(negedge clk);
        #1;
    endtask
    task automatic send(input logic [31:0] v, input logic [4:0] rt);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_rt = rt;
        while (!bus.in_ready && n < 60) begin
            tick();
            n++;
        end
        chk("send_in_ready_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        model_push(v, rt);
    endtask
    task automatic pulse_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) tick();
        reset = 1'b1;
    endtask
    vec_t tbl[10];
    initial begin
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        bus.in_rt = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_out_eop", 32'(bus.out_eop), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b1;
        tick();
        tbl[0] = '{32'hFFFF8000, 5'd8,  1, 32'h24088000, 2'd0, 32'h0};
        tbl[1] = '{32'h0000ABCD, 5'd8,  1, 32'h3408ABCD, 2'd1, 32'h0};
        tbl[2] = '{32'h12340000, 5'd8,  1, 32'h3C081234, 2'd2, 32'h0};
        tbl[3] = '{32'h12345678, 5'd9,  2, 32'h3C091234, 2'd2, 32'h35295678};
        tbl[4] = '{32'h00000000, 5'd1,  1, 32'h24010000, 2'd0, 32'h0};
        tbl[5] = '{32'h00008000, 5'd2,  1, 32'h34028000, 2'd1, 32'h0};
        tbl[6] = '{32'hFFFF0000, 5'd3,  1, 32'h3C03FFFF, 2'd2, 32'h0};
        tbl[7] = '{32'h80000000, 5'd4,  1, 32'h3C048000, 2'd2, 32'h0};
        tbl[8] = '{32'hFFFFFFFF, 5'd31, 1, 32'h241FFFFF, 2'd0, 32'h0};
        tbl[9] = '{32'h00010001, 5'd5,  2, 32'h3C050001, 2'd2, 32'h34A50001};
        rdy_ctl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].v, tbl[i].rt);
            chk("tbl_valid_a", 32'(bus.out_valid), 32'd1);
            chk("tbl_instr_a", bus.out_instr, tbl[i].i0);
            chk("tbl_eop_a", 32'(bus.out_eop), 32'(tbl[i].e0));
            chk("tbl_last_a", 32'(bus.out_last), 32'(tbl[i].n == 1));
            if (tbl[i].n == 2) begin
                tick();
                chk("tbl_valid_b", 32'(bus.out_valid), 32'd1);
                chk("tbl_instr_b", bus.out_instr, tbl[i].i1);
                chk("tbl_eop_b", 32'(bus.out_eop), 32'd1);
                chk("tbl_last_b", 32'(bus.out_last), 32'd1);
            end
            tick();
            chk("tbl_idle_in_ready", 32'(bus.in_ready), 32'd1);
            chk("tbl_idle_valid", 32'(bus.out_valid), 32'd0);
        end
        pulse_reset(1);
        rdy_ctl = 1'b0;
        send(32'h12345678, 5'd9);
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall_instr", bus.out_instr, 32'h3C091234);
            chk("t4_stall_last", 32'(bus.out_last), 32'd0);
            if (i < 2) tick();
        end
        rdy_ctl = 1'b1;
        tick();
        tick();
        chk("t4_second_instr", bus.out_instr, 32'h35295678);
        chk("t4_second_eop", 32'(bus.out_eop), 32'd1);
        chk("t4_second_last", 32'(bus.out_last), 32'd1);
        tick();
        chk("t4_count", 32'(bus.out_count), 32'd2);
        send(32'h12345678, 5'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_valid", 32'(bus.out_valid), 32'd0);
            chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
            chk("t5_count", 32'(bus.out_count), 32'd2);
            tick();
        end
        rdy_ctl = 1'b0;
        send(32'h00000042, 5'd7);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("t1_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_count", 32'(bus.out_count), 32'd0);
        chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t1_instr", bus.out_instr, 32'd0);
        reset = 1'b1;
        rdy_ctl = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            send(32'(i + 1), 5'd6);
            tick();
            chk("t6_count_wrap", 32'(bus.out_count), 32'(want[i]));
        end
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] v;
            logic [31:0] r = $urandom;
            case ($urandom_range(0, 4))
                0: v = {{16{r[15]}}, r[15:0]};
                1: v = {16'h0, 1'b1, r[14:0]};
                2: v = {r[31:16] | 16'h1, 16'h0};
                3: v = r;
                default: v = ($urandom_range(0, 1) != 0) ? 32'h00008000 : 32'h80000000;
            endcase
            send(v, ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
            repeat ($urandom_range(0, 2)) tick();
        end
        for (int n = 0; n < 100 && (exp_q.size() != 0 || bus.out_valid); n++) tick();
        rand_mode = 1'b0;
        tick();
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(bus.in_ready), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
